// File: rtl/sprite_engine_if.sv
// Pixel/bus bundle between VGA timing, sprite_engine, the sprite ROM and the layer mixer.
// mirror_x exists only when SPRITE_MIRROR_EN is defined.
interface sprite_engine_if #(
    parameter int X_BITS    = 10,
    parameter int Y_BITS    = 9,
    parameter int ADDR_BITS = 13,
    parameter int FI_BITS   = 2
);
    logic                 frame_strobe;
    logic [X_BITS-1:0]    origin_x;
    logic [Y_BITS-1:0]    origin_y;
    logic                 visible;
    logic                 anim_en;
`ifdef SPRITE_MIRROR_EN
    logic                 mirror_x;
`endif
    logic [X_BITS-1:0]    raster_x;
    logic [Y_BITS-1:0]    raster_y;
    logic [ADDR_BITS-1:0] rom_addr;
    logic [11:0]          rom_data;
    logic [3:0]           red;
    logic [3:0]           grn;
    logic [3:0]           blu;
    logic                 valid;
    logic [FI_BITS-1:0]   frame_idx;

    modport master (
        output frame_strobe, origin_x, origin_y, visible, anim_en,
`ifdef SPRITE_MIRROR_EN
        output mirror_x,
`endif
        output raster_x, raster_y, rom_data,
        input  rom_addr, red, grn, blu, valid, frame_idx
    );

    modport slave (
        input  frame_strobe, origin_x, origin_y, visible, anim_en,
`ifdef SPRITE_MIRROR_EN
        input  mirror_x,
`endif
        input  raster_x, raster_y, rom_data,
        output rom_addr, red, grn, blu, valid, frame_idx
    );
endinterface

// File: rtl/sprite_engine.sv
// Pipelined, animated sprite renderer: coverage test, ROM address generation, colour-key transparency.
// Define SPRITE_MIRROR_EN to add horizontal mirroring (mirror_x, latched with the origin).
module sprite_engine #(
    parameter int          SPRITE_WID  = 40,
    parameter int          SPRITE_HGT  = 40,
    parameter int          X_BITS      = 10,
    parameter int          Y_BITS      = 9,
    parameter int          NUM_FRAMES  = 4,
    parameter int          FRAME_TICKS = 8,
    parameter int          ADDR_BITS   = 13,
    parameter logic [11:0] TRANSP_KEY  = 12'h000,
    localparam int         FI_BITS     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input logic           clk_i,
    input logic           rst_i,
    sprite_engine_if.slave spr
);
    localparam int                   TICK_BITS  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TICK_BITS-1:0] TICK_LAST  = TICK_BITS'(FRAME_TICKS - 1);
    localparam logic [FI_BITS-1:0]   FRAME_LAST = FI_BITS'(NUM_FRAMES - 1);
    localparam logic [ADDR_BITS-1:0] FRAME_SIZE = ADDR_BITS'(SPRITE_WID * SPRITE_HGT);
    localparam logic [ADDR_BITS-1:0] WID_A      = ADDR_BITS'(SPRITE_WID);
    localparam logic [X_BITS:0]      WID_X      = (X_BITS + 1)'(SPRITE_WID);
    localparam logic [Y_BITS:0]      HGT_Y      = (Y_BITS + 1)'(SPRITE_HGT);
`ifdef SPRITE_MIRROR_EN
    localparam logic [X_BITS-1:0]    WID_M1     = X_BITS'(SPRITE_WID - 1);
`endif

    logic [X_BITS-1:0]    sx_q, sx_d;
    logic [Y_BITS-1:0]    sy_q, sy_d;
    logic                 vis_q, vis_d;
`ifdef SPRITE_MIRROR_EN
    logic                 mirror_q, mirror_d;
`endif
    logic [TICK_BITS-1:0] tick_q, tick_d;
    logic [FI_BITS-1:0]   frame_q, frame_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 hit0_q, hit0_d;
    logic [11:0]          rgb_q, rgb_d;
    logic                 valid_q, valid_d;

    logic [X_BITS:0]      rx_ext, sx_ext, x_end;
    logic [Y_BITS:0]      ry_ext, sy_ext, y_end;
    logic                 in_rect;
    logic [X_BITS-1:0]    lx, col;
    logic [Y_BITS-1:0]    ly;
    logic [ADDR_BITS-1:0] addr_calc;

    // Shadow origin/enable and animation only move on the vertical-blank strobe.
    always_comb begin
        sx_d    = sx_q;
        sy_d    = sy_q;
        vis_d   = vis_q;
`ifdef SPRITE_MIRROR_EN
        mirror_d = mirror_q;
`endif
        tick_d  = tick_q;
        frame_d = frame_q;
        if (spr.frame_strobe) begin
            sx_d  = spr.origin_x;
            sy_d  = spr.origin_y;
            vis_d = spr.visible;
`ifdef SPRITE_MIRROR_EN
            mirror_d = spr.mirror_x;
`endif
            if (spr.anim_en) begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
        end
    end

    // Bounds carry one extra bit so a sprite hanging off the right/bottom edge never wraps to 0.
    always_comb begin
        rx_ext  = {1'b0, spr.raster_x};
        sx_ext  = {1'b0, sx_q};
        x_end   = sx_ext + WID_X;
        ry_ext  = {1'b0, spr.raster_y};
        sy_ext  = {1'b0, sy_q};
        y_end   = sy_ext + HGT_Y;
        in_rect = (rx_ext >= sx_ext) && (rx_ext < x_end) &&
                  (ry_ext >= sy_ext) && (ry_ext < y_end);
        lx      = spr.raster_x - sx_q;
        ly      = spr.raster_y - sy_q;
`ifdef SPRITE_MIRROR_EN
        col     = mirror_q ? (WID_M1 - lx) : lx;
`else
        col     = lx;
`endif
        addr_calc = ADDR_BITS'(frame_q) * FRAME_SIZE
                  + ADDR_BITS'(ly) * WID_A
                  + ADDR_BITS'(col);
        addr_d  = in_rect ? addr_calc : addr_q;
        hit0_d  = in_rect & vis_q;
    end

    // ROM data for the address registered last cycle is present now, so hit0_q is its aligned flag.
    always_comb begin
        rgb_d   = hit0_q ? spr.rom_data : 12'h000;
        valid_d = hit0_q && (spr.rom_data != TRANSP_KEY);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sx_q     <= '0;
            sy_q     <= '0;
            vis_q    <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            mirror_q <= 1'b0;
`endif
            tick_q   <= '0;
            frame_q  <= '0;
            addr_q   <= '0;
            hit0_q   <= 1'b0;
            rgb_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            vis_q    <= vis_d;
`ifdef SPRITE_MIRROR_EN
            mirror_q <= mirror_d;
`endif
            tick_q   <= tick_d;
            frame_q  <= frame_d;
            addr_q   <= addr_d;
            hit0_q   <= hit0_d;
            rgb_q    <= rgb_d;
            valid_q  <= valid_d;
        end
    end

    assign spr.rom_addr  = addr_q;
    assign spr.red       = rgb_q[11:8];
    assign spr.grn       = rgb_q[7:4];
    assign spr.blu       = rgb_q[3:0];
    assign spr.valid     = valid_q;
    assign spr.frame_idx = frame_q;
endmodule

// File: tb/tb_sprite_engine.sv
// Scoreboard bench for sprite_engine: a reference model predicts ROM address (1 clk) and pixel (2 clk).
module tb_sprite_engine;
    localparam int X_BITS = 10, Y_BITS = 9, ADDR_BITS = 13, FI_BITS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_engine_if #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .ADDR_BITS(ADDR_BITS), .FI_BITS(FI_BITS)) spr();
    sprite_engine dut (.clk_i(clk), .rst_i(rst), .spr(spr));

    int total = 0;
    int bad   = 0;

    logic        ovr_en;
    logic [11:0] ovr_val;

    function automatic logic [11:0] rom_fn(input logic [ADDR_BITS-1:0] a);
        logic [11:0] t;
        t = a[11:0];
        return t * 12'd7 + 12'h5A3;
    endfunction

    assign spr.rom_data = ovr_en ? ovr_val : rom_fn(spr.rom_addr);

    // reference model state
    int m_sx, m_sy, m_frame, m_tick, m_addr;
    bit m_vis, m_mir;

    typedef struct { int stamp; int addr; } a_t;
    typedef struct { int stamp; logic v; logic [11:0] rgb; } p_t;
    a_t aq[$];
    p_t pq[$];
    int mcyc = 0;

    always begin : monitor
        a_t a;
        p_t p;
        @(posedge clk);
        #1;
        mcyc++;
        if (aq.size() > 0 && aq[0].stamp + 1 == mcyc) begin
            a = aq.pop_front();
            total++;
            if (spr.rom_addr !== ADDR_BITS'(a.addr)) begin
                bad++;
                $display("FAIL sb_rom_addr cyc=%0d got=%0d exp=%0d", mcyc, spr.rom_addr, a.addr);
            end
        end
        if (pq.size() > 0 && pq[0].stamp + 2 == mcyc) begin
            p = pq.pop_front();
            total++;
            if (spr.valid !== p.v || {spr.red, spr.grn, spr.blu} !== p.rgb) begin
                bad++;
                $display("FAIL sb_pixel cyc=%0d got v=%0b rgb=%h exp v=%0b rgb=%h",
                         mcyc, spr.valid, {spr.red, spr.grn, spr.blu}, p.v, p.rgb);
            end
        end
    end

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_vis = 0; m_mir = 0;
        m_frame = 0; m_tick = 0; m_addr = 0;
        aq.delete();
        pq.delete();
    endtask

    // Predict this cycle's pixel, then advance one clock.
    task automatic step();
        int x, y, lx, ly, col;
        bit in_r, hit;
        logic [11:0] data;
        x = int'(spr.raster_x);
        y = int'(spr.raster_y);
        in_r = (x >= m_sx) && (x < m_sx + 40) && (y >= m_sy) && (y < m_sy + 40);
        if (in_r) begin
            lx = x - m_sx;
            ly = y - m_sy;
            col = m_mir ? (39 - lx) : lx;
            m_addr = m_frame * 1600 + ly * 40 + col;
        end
        data = ovr_en ? ovr_val : rom_fn(ADDR_BITS'(m_addr));
        hit = in_r && m_vis;
        aq.push_back('{stamp: mcyc, addr: m_addr});
        pq.push_back('{stamp: mcyc, v: (hit && data != 12'h000), rgb: (hit ? data : 12'h000)});
        if (spr.frame_strobe) begin
            m_sx = int'(spr.origin_x);
            m_sy = int'(spr.origin_y);
            m_vis = spr.visible;
`ifdef SPRITE_MIRROR_EN
            m_mir = spr.mirror_x;
`endif
            if (spr.anim_en) begin
                if (m_tick == 7) begin
                    m_tick = 0;
                    m_frame = (m_frame == 3) ? 0 : m_frame + 1;
                end else begin
                    m_tick++;
                end
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic px(input int x, input int y);
        spr.raster_x = X_BITS'(x);
        spr.raster_y = Y_BITS'(y);
        step();
    endtask

    task automatic strobe(input int ox, input int oy, input logic vis);
        spr.origin_x = X_BITS'(ox);
        spr.origin_y = Y_BITS'(oy);
        spr.visible = vis;
        spr.frame_strobe = 1'b1;
        px(0, 0);
        spr.frame_strobe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spr.frame_strobe = 1'b1;
        spr.origin_x = 10'd300;
        spr.origin_y = 9'd200;
        spr.visible = 1'b1;
        spr.anim_en = 1'b1;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        total++;
        if (spr.rom_addr !== '0 || spr.valid !== 1'b0 || {spr.red, spr.grn, spr.blu} !== 12'h000
            || spr.frame_idx !== '0) begin
            bad++;
            $display("FAIL reset_state got addr=%0d v=%0b rgb=%h fi=%0d exp all 0",
                     spr.rom_addr, spr.valid, {spr.red, spr.grn, spr.blu}, spr.frame_idx);
        end
        rst = 1'b0;
        spr.frame_strobe = 1'b0;
        spr.anim_en = 1'b0;
        // strobe was ignored under reset, so shadow origin is still (0,0)
        px(310, 210);
        total++;
        if (spr.rom_addr !== 13'd0) begin
            bad++;
            $display("FAIL reset_beats_strobe got=%0d exp=0", spr.rom_addr);
        end
        px(0, 0);
    endtask

    task automatic test_basic();
        logic [11:0] d;
        strobe(100, 50, 1'b1);
        px(100, 50);
        total++;
        if (spr.rom_addr !== 13'd0) begin
            bad++;
            $display("FAIL origin_addr got=%0d exp=0", spr.rom_addr);
        end
        px(139, 89);
        total++;
        if (spr.rom_addr !== 13'd1599) begin
            bad++;
            $display("FAIL corner_addr got=%0d exp=1599", spr.rom_addr);
        end
        px(140, 89);
        d = rom_fn(13'd1599);
        total++;
        if (spr.valid !== 1'b1 || {spr.red, spr.grn, spr.blu} !== d) begin
            bad++;
            $display("FAIL corner_pixel got v=%0b rgb=%h exp v=1 rgb=%h", spr.valid, {spr.red, spr.grn, spr.blu}, d);
        end
        px(99, 50);
        total++;
        if (spr.valid !== 1'b0) begin
            bad++;
            $display("FAIL right_outside got v=%0b exp v=0", spr.valid);
        end
        px(120, 70);
        px(100, 90);
        px(139, 50);
        px(0, 0);
    endtask

    task automatic test_colour_key();
        px(0, 0);
        ovr_en = 1'b1;
        ovr_val = 12'h000;
        px(110, 60);
        px(0, 0);
        total++;
        if (spr.valid !== 1'b0 || {spr.red, spr.grn, spr.blu} !== 12'h000) begin
            bad++;
            $display("FAIL key_transparent got v=%0b rgb=%h exp v=0 rgb=000", spr.valid, {spr.red, spr.grn, spr.blu});
        end
        ovr_val = 12'hF80;
        px(110, 60);
        px(0, 0);
        total++;
        if (spr.valid !== 1'b1 || spr.red !== 4'hF || spr.grn !== 4'h8 || spr.blu !== 4'h0) begin
            bad++;
            $display("FAIL key_opaque got v=%0b rgb=%h exp v=1 rgb=f80", spr.valid, {spr.red, spr.grn, spr.blu});
        end
        px(0, 0);
        ovr_en = 1'b0;
    endtask

    task automatic test_anim();
        spr.anim_en = 1'b1;
        repeat (8) strobe(100, 50, 1'b1);
        total++;
        if (spr.frame_idx !== 2'd1) begin
            bad++;
            $display("FAIL anim_8 got=%0d exp=1", spr.frame_idx);
        end
        px(100, 50);
        total++;
        if (spr.rom_addr !== 13'd1600) begin
            bad++;
            $display("FAIL anim_addr got=%0d exp=1600", spr.rom_addr);
        end
        repeat (24) strobe(100, 50, 1'b1);
        total++;
        if (spr.frame_idx !== 2'd0) begin
            bad++;
            $display("FAIL anim_32 got=%0d exp=0", spr.frame_idx);
        end
        repeat (8) strobe(100, 50, 1'b1);
        spr.anim_en = 1'b0;
        repeat (8) strobe(100, 50, 1'b1);
        total++;
        if (spr.frame_idx !== 2'd1) begin
            bad++;
            $display("FAIL anim_hold got=%0d exp=1", spr.frame_idx);
        end
        px(101, 51);
    endtask

    task automatic test_no_tear();
        strobe(200, 100, 1'b1);
        px(200, 100);
        spr.origin_x = 10'd250;
        px(200, 100);
        px(239, 139);
        total++;
        if (spr.rom_addr !== 13'd3199) begin
            bad++;
            $display("FAIL no_tear got=%0d exp=3199", spr.rom_addr);
        end
        px(250, 100);
        strobe(250, 100, 1'b1);
        px(250, 100);
    endtask

    task automatic test_same_cycle_strobe();
        spr.origin_x = 10'd0;
        spr.origin_y = 9'd0;
        spr.frame_strobe = 1'b1;
        px(260, 105);
        spr.frame_strobe = 1'b0;
        total++;
        if (spr.rom_addr !== 13'd1810) begin
            bad++;
            $display("FAIL strobe_same_cycle got=%0d exp=1810", spr.rom_addr);
        end
        px(260, 105);
        px(5, 5);
    endtask

    task automatic test_screen_edge();
        strobe(620, 460, 1'b1);
        px(639, 479);
        px(0, 470);
        px(640, 479);
        strobe(1000, 500, 1'b1);
        px(1023, 511);
        total++;
        if (spr.rom_addr !== 13'd2063) begin
            bad++;
            $display("FAIL edge_no_wrap got=%0d exp=2063", spr.rom_addr);
        end
        px(5, 505);
        px(999, 505);
        px(1010, 3);
    endtask

    task automatic test_reset_midline();
        strobe(100, 50, 1'b1);
        for (int i = 0; i < 6; i++) px(100 + i, 50);
        rst = 1'b1;
        spr.raster_x = 10'd106;
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        total++;
        if (spr.valid !== 1'b0 || spr.rom_addr !== '0 || spr.frame_idx !== '0) begin
            bad++;
            $display("FAIL reset_midline got v=%0b addr=%0d fi=%0d exp 0", spr.valid, spr.rom_addr, spr.frame_idx);
        end
        for (int i = 7; i < 11; i++) px(100 + i, 50);
    endtask

`ifdef SPRITE_MIRROR_EN
    task automatic test_mirror();
        spr.mirror_x = 1'b1;
        strobe(100, 50, 1'b1);
        px(100, 50);
        total++;
        if (spr.rom_addr !== 13'd39) begin
            bad++;
            $display("FAIL mirror_addr got=%0d exp=39", spr.rom_addr);
        end
        px(139, 51);
        spr.mirror_x = 1'b0;
        strobe(100, 50, 1'b1);
        px(100, 50);
    endtask
`endif

    initial begin
        rst = 1'b1;
        ovr_en = 1'b0;
        ovr_val = 12'h000;
        spr.frame_strobe = 1'b0;
        spr.origin_x = '0;
        spr.origin_y = '0;
        spr.visible = 1'b0;
        spr.anim_en = 1'b0;
`ifdef SPRITE_MIRROR_EN
        spr.mirror_x = 1'b0;
`endif
        spr.raster_x = '0;
        spr.raster_y = '0;

        test_reset();
        test_basic();
        test_colour_key();
        test_anim();
        test_no_tear();
        test_same_cycle_strobe();
        test_screen_edge();
        test_reset_midline();
`ifdef SPRITE_MIRROR_EN
        test_mirror();
`endif
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        total++;
        if (aq.size() != 0 || pq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got addr_q=%0d pix_q=%0d exp 0", aq.size(), pq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
